pipe_sched: RTL and testbench
=============================

Name: pipe_sched

Overview:
Round-robin scheduler that shares one 2-cycle pipe multiplier datapath (16-bit × 2-bit coefficient, with 0x0000/0xFFFF passthrough) between NUM_REQ requesters. Accepts requests over valid/ready, drives the pipe's enable, coefficient and data inputs, and tracks each in-flight operation's requester ID through the fixed pipe latency. Captures pipe outputs into a response FIFO and returns them tagged with the requester ID. Uses credit-based issue because the pipe cannot stall.

Parameters:
NUM_REQ, 2, number of requesters (2..8); ID_W = max(1, $clog2(NUM_REQ)) is derived, not a parameter.
PIPE_LAT, 2, cycles from the pipe input-sample edge to valid pipe output.
RSP_DEPTH, 4, response FIFO entries; also the total credit pool (power of two, ≥ PIPE_LAT).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_cf  in  2*NUM_REQ  packed coefficients; requester i uses bits [2i+1:2i]
req_data0  in  16*NUM_REQ  packed operand 0
req_data1  in  16*NUM_REQ  packed operand 1
pipe_en  out  1  pipe i_en
pipe_cf  out  2  pipe i_cf
pipe_data0  out  16  pipe i_data0
pipe_data1  out  16  pipe i_data1
pipe_res0  in  16  pipe o_data0
pipe_res1  in  16  pipe o_data1
rsp_valid  out  1  response FIFO non-empty
rsp_ready  in  1  response consumer accept
rsp_id  out  ID_W  requester index of head response
rsp_data0  out  16  head result 0
rsp_data1  out  16  head result 1

Behaviour:
- Reset: FIFO and in-flight tracker are emptied, round-robin pointer is set so requester 0 has top priority, and all outputs are 0 (rsp_valid=0, req_ready=0, pipe_en=0).
- Reset mid-operation discards in-flight and queued results. The pipe's own synchronous reset is driven elsewhere.
- Credit: occ = fifo_count + inflight_count. Issue is allowed only when occ < RSP_DEPTH.
- A FIFO pop frees its credit in the following cycle, not the same cycle.
- Arbitration is combinational each cycle. Among the req_valid bits, the first index at or after (last_grant+1) mod NUM_REQ wins. If issue is allowed, req_ready[winner]=1.
- On a handshake in cycle T: last_grant <= winner.
- In cycle T, pipe_en=1 and pipe_cf/pipe_data0/pipe_data1 carry the winner's fields combinationally.
- When there is no issue, pipe_en=0 and pipe_cf/pipe_data0/pipe_data1 = 0.
- In-flight tracker: a PIPE_LAT-stage shift register of {valid, id}, loaded at the end of cycle T. Pipe results are valid during cycle T+PIPE_LAT.
- When the final stage is valid, push {id, pipe_res0, pipe_res1} into the FIFO. The FIFO can never be full at that point by credit construction; an assertion checks this.
- Samples of pipe_res while the final stage is invalid are ignored, including the pipe's held outputs when pipe_en=0.
- Response FIFO is show-ahead. Pop on rsp_valid && rsp_ready. Push and pop in the same cycle are both honoured.
- Minimum request-to-rsp_valid latency is PIPE_LAT+1 = 3 cycles.
- Sustained throughput is 1 op/cycle while rsp_ready=1.
- A requester whose req_valid drops without a handshake has no side effect. The request payload must be stable only during the handshake cycle.

Optional Feature:
PIPE_SCHED_PERF_EN
- Defined: adds these ports:
  - perf_clr (in, 1): synchronous clear of all counters.
  - perf_grant_cnt (out, 16*NUM_REQ): saturating per-requester handshake count.
  - perf_stall_cnt (out, 16): saturating count of cycles with any req_valid=1 but no issue due to credits.
  - All counters reset to 0.
- Undefined: these ports and the counter logic are absent; functional behaviour is identical.

Decomposition:
- Package pipe_sched_pkg holds:
  - PIPE_DATA_W=16, PIPE_CF_W=2 constants;
  - typedef pipe_rsp_t {id, data0, data1};
  - function rr_pick(valid, last) returning the one-hot winner.
- Sub-module pipe_sched_fifo: generic show-ahead synchronous FIFO with count output, parameterised by depth and type.

Test Plan:
- Single op: req0 data0=0x0003, data1=0x0010, cf=2 at cycle T -> rsp_valid at T+3 with id=0, data0=0x0006, data1=0x0020.
- Passthrough: req1 data0=0xFFFF, data1=0x0000, cf=3 -> rsp id=1, data0=0xFFFF, data1=0x0000.
- Fairness: both requesters held valid for 8 cycles with rsp_ready=1 -> grants alternate 0,1,0,1…, one handshake per cycle, response ids in the same order.
- Backpressure: rsp_ready=0 with continuous requests -> exactly 4 handshakes, then req_ready=0. After one pop, one more handshake occurs the following cycle. No result is lost or duplicated.
- Reset mid-flight: assert rst with 2 ops in flight and 1 queued -> rsp_valid=0 immediately, and no stale response appears after reset release.
- PIPE_SCHED_PERF_EN: backpressure scenario -> perf_grant_cnt[0]+[1]=5 and perf_stall_cnt counts the blocked cycles; perf_clr -> all counters 0.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// Shared types and helpers for the pipe_sched scheduler: datapath widths,
// the tagged response record and the round-robin pick function.
package pipe_sched_pkg;

  localparam int PIPE_DATA_W = 16;
  localparam int PIPE_CF_W   = 2;
  localparam int MAX_REQ     = 8;
  localparam int MAX_ID_W    = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0]    id;
    logic [PIPE_DATA_W-1:0] data0;
    logic [PIPE_DATA_W-1:0] data1;
  } pipe_rsp_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot winner: first valid index at or after (last+1) mod n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                 input logic [MAX_ID_W-1:0] last,
                                                 input int                  n);
    logic [MAX_REQ-1:0]  grant;
    logic                found;
    logic [MAX_ID_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = MAX_ID_W'((int'(last) + k) % n);
      if (k <= n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/pipe_sched_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; depth must be a power of two >= 2.
module pipe_sched_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pipe_sched.sv
// Round-robin, credit-based scheduler sharing one fixed-latency pipe multiplier.
// Optional counters are enabled by defining PIPE_SCHED_PERF_EN.
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int PIPE_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [PIPE_CF_W*NUM_REQ-1:0]      req_cf,
  input  logic [PIPE_DATA_W*NUM_REQ-1:0]    req_data0,
  input  logic [PIPE_DATA_W*NUM_REQ-1:0]    req_data1,
  output logic                              pipe_en,
  output logic [PIPE_CF_W-1:0]              pipe_cf,
  output logic [PIPE_DATA_W-1:0]            pipe_data0,
  output logic [PIPE_DATA_W-1:0]            pipe_data1,
  input  logic [PIPE_DATA_W-1:0]            pipe_res0,
  input  logic [PIPE_DATA_W-1:0]            pipe_res1,
  input  logic                              rsp_ready,
`ifdef PIPE_SCHED_PERF_EN
  input  logic                              perf_clr,
  output logic [16*NUM_REQ-1:0]             perf_grant_cnt,
  output logic [15:0]                       perf_stall_cnt,
`endif
  output logic                              rsp_valid,
  output logic [id_width(NUM_REQ)-1:0]      rsp_id,
  output logic [PIPE_DATA_W-1:0]            rsp_data0,
  output logic [PIPE_DATA_W-1:0]            rsp_data1
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [MAX_REQ-1:0] valid_ext, grant_ext;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_idx;
  logic               issue_ok, issue;

  logic [PIPE_LAT-1:0] stg_valid_q;
  logic [ID_W-1:0]     stg_id_q [PIPE_LAT];

  logic [CNT_W-1:0] fifo_count, inflight_count;
  logic [CNT_W:0]   occ;
  logic             fifo_full, fifo_empty, rsp_push, rsp_pop;
  pipe_rsp_t        rsp_in, rsp_head;
  logic             unused_head_id;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
    grant_ext                = rr_pick(valid_ext, MAX_ID_W'(last_grant_q), NUM_REQ);
    grant                    = grant_ext[NUM_REQ-1:0];
    win_idx                  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = ID_W'(i);
    end
  end

  // Credits cover both in-flight ops and queued responses, so a push never finds the FIFO full.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight_count = inflight_count + CNT_W'(stg_valid_q[i]);
    end
  end

  assign occ      = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign issue_ok = !rst && (occ < (CNT_W+1)'(RSP_DEPTH));
  assign issue    = issue_ok && (|grant_ext);
  assign req_ready = issue_ok ? grant : '0;

  always_comb begin
    pipe_en      = issue;
    pipe_cf      = '0;
    pipe_data0   = '0;
    pipe_data1   = '0;
    last_grant_d = last_grant_q;
    if (issue) begin
      pipe_cf      = req_cf[int'(win_idx)*PIPE_CF_W +: PIPE_CF_W];
      pipe_data0   = req_data0[int'(win_idx)*PIPE_DATA_W +: PIPE_DATA_W];
      pipe_data1   = req_data1[int'(win_idx)*PIPE_DATA_W +: PIPE_DATA_W];
      last_grant_d = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      stg_valid_q  <= '0;
      for (int i = 0; i < PIPE_LAT; i++) stg_id_q[i] <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      stg_valid_q[0] <= issue;
      stg_id_q[0]    <= win_idx;
      for (int i = 1; i < PIPE_LAT; i++) begin
        stg_valid_q[i] <= stg_valid_q[i-1];
        stg_id_q[i]    <= stg_id_q[i-1];
      end
    end
  end

  // Pipe outputs are only captured when the tracker says an op lands this cycle.
  assign rsp_push = stg_valid_q[PIPE_LAT-1];
  assign rsp_in   = '{id:    MAX_ID_W'(stg_id_q[PIPE_LAT-1]),
                      data0: pipe_res0,
                      data1: pipe_res1};
  assign rsp_pop  = rsp_valid && rsp_ready;

  pipe_sched_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (pipe_rsp_t)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rsp_push),
    .push_data_i (rsp_in),
    .pop_i       (rsp_pop),
    .pop_data_o  (rsp_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rsp_valid      = !fifo_empty;
  assign rsp_id         = rsp_valid ? rsp_head.id[ID_W-1:0] : '0;
  assign rsp_data0      = rsp_valid ? rsp_head.data0 : '0;
  assign rsp_data1      = rsp_valid ? rsp_head.data1 : '0;
  assign unused_head_id = ^rsp_head.id;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) rsp_push |-> !fifo_full);

`ifdef PIPE_SCHED_PERF_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      if ((|req_valid) && !issue_ok && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && (grant_cnt_q[i] != 16'hFFFF))
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf_out
    assign perf_grant_cnt[16*g +: 16] = grant_cnt_q[g];
  end
  assign perf_stall_cnt = stall_cnt_q;
`else
  // Counters are compiled out; the scheduling path above is unchanged.
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Self-checking bench for pipe_sched: behavioural 2-cycle pipe model plus a response scoreboard.
module tb_pipe_sched;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid, req_ready;
  logic [2*NUM_REQ-1:0] req_cf;
  logic [16*NUM_REQ-1:0] req_data0, req_data1;
  logic                 pipe_en;
  logic [1:0]           pipe_cf;
  logic [15:0]          pipe_data0, pipe_data1, pipe_res0, pipe_res1;
  logic                 rsp_ready, rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_data0, rsp_data1;
`ifdef PIPE_SCHED_PERF_EN
  logic                 perf_clr;
  logic [16*NUM_REQ-1:0] perf_grant_cnt;
  logic [15:0]          perf_stall_cnt;
`endif

  pipe_sched #(.NUM_REQ(NUM_REQ), .PIPE_LAT(2), .RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cf     (req_cf),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .pipe_en    (pipe_en),
    .pipe_cf    (pipe_cf),
    .pipe_data0 (pipe_data0),
    .pipe_data1 (pipe_data1),
    .pipe_res0  (pipe_res0),
    .pipe_res1  (pipe_res1),
    .rsp_ready  (rsp_ready),
`ifdef PIPE_SCHED_PERF_EN
    .perf_clr       (perf_clr),
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data0  (rsp_data0),
    .rsp_data1  (rsp_data1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] gold(input logic [15:0] d, input logic [1:0] cf);
    if (d == 16'h0000 || d == 16'hFFFF) return d;
    return 16'(32'(d) * 32'(cf));
  endfunction

  // Behavioural pipe: samples on enable, result valid two cycles later, holds otherwise.
  logic [15:0] p1_0 = '0, p1_1 = '0, p2_0 = '0, p2_1 = '0;
  always @(posedge clk) begin
    if (pipe_en) begin
      p1_0 <= gold(pipe_data0, pipe_cf);
      p1_1 <= gold(pipe_data1, pipe_cf);
    end
    p2_0 <= p1_0;
    p2_1 <= p1_1;
  end
  assign pipe_res0 = p2_0;
  assign pipe_res1 = p2_1;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [15:0]     d0;
    logic [15:0]     d1;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          hs_cnt      = 0;
  int          model_last  = NUM_REQ - 1;

  function automatic int exp_winner(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Monitor: predicts each grant with its own round-robin model and scores every response.
  always @(negedge clk) begin
    if (!rst) begin
      if (|req_ready) begin
        int   w;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_t e;
        w       = exp_winner(req_valid, model_last);
        exp_rdy = (w < 0) ? '0 : NUM_REQ'(1) << w;
        vectors++;
        if (req_ready !== exp_rdy) begin
          miscompares++;
          $display("FAIL grant_order: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        if (w >= 0) begin
          e.id = ID_W'(w);
          e.d0 = gold(req_data0[16*w +: 16], req_cf[2*w +: 2]);
          e.d1 = gold(req_data1[16*w +: 16], req_cf[2*w +: 2]);
          sb_q.push_back(e);
          model_last = w;
        end
        hs_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: id=%0d d0=%h d1=%h with nothing outstanding", rsp_id, rsp_data0, rsp_data1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if ({rsp_id, rsp_data0, rsp_data1} !== {e.id, e.d0, e.d1}) begin
            miscompares++;
            $display("FAIL rsp_data: got id=%0d %h %h expected id=%0d %h %h",
                     rsp_id, rsp_data0, rsp_data1, e.id, e.d0, e.d1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_payload();
    req_cf    = 4'($urandom);
    req_data0 = 32'($urandom);
    req_data1 = 32'($urandom);
  endtask

  task automatic drain(input string name);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    randomize_payload();
`ifdef PIPE_SCHED_PERF_EN
    perf_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== '0 || pipe_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b pipe_en=%b expected 00/0", req_ready, pipe_en);
    end
    vectors++;
    if ({pipe_cf, pipe_data0, pipe_data1} !== '0) begin
      miscompares++;
      $display("FAIL reset_pipe_bus: cf=%h d0=%h d1=%h expected 0", pipe_cf, pipe_data0, pipe_data1);
    end
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data0, rsp_data1} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: valid=%b id=%0d d0=%h d1=%h expected all 0", rsp_valid, rsp_id, rsp_data0, rsp_data1);
    end
`ifdef PIPE_SCHED_PERF_EN
    vectors++;
    if ({perf_grant_cnt, perf_stall_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_perf: grant=%h stall=%h expected 0", perf_grant_cnt, perf_stall_cnt);
    end
`endif
    tick();
    req_valid  = '0;
    rst        = 1'b0;
    model_last = NUM_REQ - 1;
    sb_q.delete();
    @(negedge clk);
    vectors++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: req_ready=%b rsp_valid=%b expected 00/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_op();
    tick();
    rsp_ready      = 1'b1;
    req_cf[1:0]    = 2'd2;
    req_data0[15:0] = 16'h0003;
    req_data1[15:0] = 16'h0010;
    req_valid      = 2'b01;
    @(negedge clk);
    vectors++;
    if ({pipe_en, pipe_cf, pipe_data0, pipe_data1} !== {1'b1, 2'd2, 16'h0003, 16'h0010}) begin
      miscompares++;
      $display("FAIL single_pipe_drive: en=%b cf=%0d d0=%h d1=%h expected 1 2 0003 0010",
               pipe_en, pipe_cf, pipe_data0, pipe_data1);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== (k == 3)) begin
        miscompares++;
        $display("FAIL single_latency: cycle T+%0d rsp_valid=%b expected %b", k, rsp_valid, (k == 3));
      end
      if (k == 3) begin
        vectors++;
        if ({rsp_id, rsp_data0, rsp_data1} !== {1'b0, 16'h0006, 16'h0020}) begin
          miscompares++;
          $display("FAIL single_result: id=%0d d0=%h d1=%h expected 0 0006 0020", rsp_id, rsp_data0, rsp_data1);
        end
      end
    end
    tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_dup: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_passthrough();
    bit seen = 1'b0;
    tick();
    req_cf[3:2]      = 2'd3;
    req_data0[31:16] = 16'hFFFF;
    req_data1[31:16] = 16'h0000;
    req_valid        = 2'b10;
    @(negedge clk);
    tick();
    req_valid = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        vectors++;
        if ({rsp_id, rsp_data0, rsp_data1} !== {1'b1, 16'hFFFF, 16'h0000}) begin
          miscompares++;
          $display("FAIL passthrough: id=%0d d0=%h d1=%h expected 1 FFFF 0000", rsp_id, rsp_data0, rsp_data1);
        end
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL passthrough_timeout: rsp_valid=0 expected a response within 10 cycles");
    end
  endtask

  task automatic test_fairness();
    int start = hs_cnt;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      randomize_payload();
      req_valid = 2'b11;
      @(negedge clk);
      vectors++;
      if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL fairness_cycle%0d: req_ready=%b expected %b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    tick();
    req_valid = '0;
    vectors++;
    if (hs_cnt - start != 8) begin
      miscompares++;
      $display("FAIL fairness_throughput: handshakes=%0d expected 8", hs_cnt - start);
    end
    drain("fairness");
  endtask

  task automatic test_back_to_back_backpressure();
    int start;
`ifdef PIPE_SCHED_PERF_EN
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
`endif
    start     = hs_cnt;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      randomize_payload();
      req_valid = 2'b11;
      @(negedge clk);
      vectors++;
      if ((|req_ready) !== (c < 4)) begin
        miscompares++;
        $display("FAIL backpressure_cycle%0d: issue=%b expected %b", c, |req_ready, (c < 4));
      end
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL credit_pop_cycle: req_ready=%b expected 00", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ((|req_ready) !== 1'b1) begin
      miscompares++;
      $display("FAIL credit_return: req_ready=%b expected one grant", req_ready);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL credit_refull: req_ready=%b expected 00", req_ready);
    end
    tick();
    req_valid = '0;
    vectors++;
    if (hs_cnt - start != 5) begin
      miscompares++;
      $display("FAIL backpressure_count: handshakes=%0d expected 5", hs_cnt - start);
    end
`ifdef PIPE_SCHED_PERF_EN
    @(negedge clk);
    vectors++;
    if (32'(perf_grant_cnt[15:0]) + 32'(perf_grant_cnt[31:16]) != 5 || perf_stall_cnt !== 16'd6) begin
      miscompares++;
      $display("FAIL perf_counts: grants=%0d+%0d stall=%0d expected sum 5 stall 6",
               perf_grant_cnt[15:0], perf_grant_cnt[31:16], perf_stall_cnt);
    end
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({perf_grant_cnt, perf_stall_cnt} !== '0) begin
      miscompares++;
      $display("FAIL perf_clr: grant=%h stall=%h expected 0", perf_grant_cnt, perf_stall_cnt);
    end
`endif
    drain("backpressure");
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      randomize_payload();
      req_valid = 2'b01;
    end
    tick();
    req_valid = '0;
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midflight_setup: rsp_valid=%b expected 1", rsp_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL midflight_reset: rsp_valid=%b req_ready=%b expected 0/00", rsp_valid, req_ready);
    end
    sb_q.delete();
    model_last = NUM_REQ - 1;
    tick();
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_rsp_cycle%0d: rsp_valid=%b expected 0", i, rsp_valid);
      end
    end
    tick();
    randomize_payload();
    req_valid = 2'b11;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL priority_after_reset: req_ready=%b expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    drain("midflight");
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_passthrough();
    test_fairness();
    test_back_to_back_backpressure();
    test_reset_midflight();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
